// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader and anything that
// talks to the instruction RAM:
//   - opcode constants of the 2-bit instruction set
//   - loader FSM state encodings
//   - default RAM geometry (address width, word width, depth)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    // Default RAM geometry; DEPTH is always 2**ADDR_W.
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_INSTR_W = 2;
    localparam int DEF_DEPTH   = 4;

    // Instruction opcodes.
    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_JNO  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // Loader FSM state encodings.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction RAM read by the program counter. A program
// arrives as a valid/ready stream, one instruction per beat, and is written to
// consecutive RAM addresses starting at 0. If the program ends early
// (in_last before the top address) the remaining addresses are padded with
// HALT. One more beat carries a checksum (sum of the instruction words, mod
// 2**INSTR_W, padding excluded); the CPU is released only when it matches.
//
// Ports
//   clock     in   single clock, all state on posedge
//   reset_n   in   synchronous active-low reset
//   start     in   begin a load (honoured in IDLE, DONE, ERROR)
//   in_valid  in   stream word present
//   in_ready  out  loader accepts a word this cycle (decoded from state)
//   in_data   in   instruction word, or checksum on the final beat
//   in_last   in   final instruction beat marker (ignored on checksum beat)
//   wr_en     out  RAM write strobe, one-cycle pulse per word
//   wr_addr   out  RAM write address
//   wr_data   out  RAM write data
//   cpu_hold  out  high keeps the CPU/PC in reset
//   done      out  program loaded and checksum matched
//   err       out  load failed (overrun or checksum mismatch)
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(OP_HALT);

    logic [2:0]         state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [INSTR_W-1:0] csum_reg;
    logic               wr_en_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [INSTR_W-1:0] wr_data_reg;
    logic               cpu_hold_reg;
    logic               done_reg;
    logic               err_reg;

    logic               accept;

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
    assign accept   = in_valid & in_ready;

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign cpu_hold = cpu_hold_reg;
    assign done     = done_reg;
    assign err      = err_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            csum_reg     <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            cpu_hold_reg <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            // Write strobe is a pulse; it is re-armed only by a beat or a fill.
            wr_en_reg <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_reg    <= ST_LOAD;
                        addr_reg     <= '0;
                        csum_reg     <= '0;
                        cpu_hold_reg <= 1'b1;
                        done_reg     <= 1'b0;
                        err_reg      <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= addr_reg;
                        wr_data_reg <= in_data;
                        csum_reg    <= csum_reg + in_data;
                        if (addr_reg == LAST_ADDR) begin
                            // Top address reached: the counter is left here
                            // rather than wrapping back onto address 0.
                            if (in_last) begin
                                state_reg <= ST_CHECK;
                            end else begin
                                state_reg <= ST_ERROR;
                                err_reg   <= 1'b1;
                            end
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                            if (in_last) begin
                                state_reg <= ST_FILL;
                            end
                        end
                    end
                end

                ST_FILL: begin
                    // addr_reg already points past the last program word, so
                    // padding starts in the cycle right after that write.
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= addr_reg;
                    wr_data_reg <= HALT_WORD;
                    if (addr_reg == LAST_ADDR) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (accept) begin
                        if (in_data == csum_reg) begin
                            state_reg    <= ST_DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
